// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: AHB transfer encodings and the data-memory
// responder state encoding.
package msrv32_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/msrv32_dmem_bytelane_ram.sv
// Single-port word RAM built from four independent byte lanes. Each lane has
// its own write enable. Reads are registered and return the pre-write contents
// when a read and a write hit the same word on the same edge.
module msrv32_dmem_bytelane_ram
  import msrv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Byte-lane write and registered read; the read samples the old contents
    always_ff @(posedge clk) begin
      if (we[lane]) begin
        mem[addr] <= wdata[8*lane +: 8];
      end
      if (re) begin
        rd_q <= mem[addr];
      end
    end

    assign rdata[8*lane +: 8] = rd_q;
  end

endmodule

// File: rtl/msrv32_dmem_responder.sv
// Data-memory responder for the msrv32 load/store port. Accepts one transfer
// at a time, optionally stalls for WAIT_STATES cycles, then completes with a
// one-cycle response. Out-of-range word indices return an error response.
module msrv32_dmem_responder
  import msrv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_ready_out,
  output logic        ahb_hresp_out
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e state, next_state;
  logic [3:0]  wait_cnt;

  logic [29:0] cap_idx;
  logic [31:0] cap_data;
  logic [3:0]  cap_mask;
  logic        cap_write;

  logic        accept;
  logic        live_write;
  logic        enter_resp;
  logic [29:0] op_idx;
  logic [31:0] op_data;
  logic [3:0]  op_mask;
  logic        op_write;
  logic        op_in_range;

  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        rd_zero;
  logic        resp_err;

  logic        unused_addr_bits;

  assign unused_addr_bits = ^ms_riscv32_mp_dmaddr_in[1:0];

  assign ahb_ready_out = (state != DMEM_WAIT);
  assign accept        = ahb_ready_out && ahb_htrans_in[1];
  assign live_write    = ms_riscv32_mp_req_in && (ms_riscv32_mp_dmwr_mask_in != 4'b0000);

  // Next-state logic: accepts from IDLE or RESP, WAIT drains the counter
  always_comb begin
    next_state = state;
    case (state)
      DMEM_IDLE, DMEM_RESP: begin
        if (accept) begin
          next_state = (WAIT_STATES > 0) ? DMEM_WAIT : DMEM_RESP;
        end else begin
          next_state = DMEM_IDLE;
        end
      end
      DMEM_WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = DMEM_RESP;
        end
      end
      default: next_state = DMEM_IDLE;
    endcase
  end

  // The memory operation runs on the edge entering RESP: with no wait states
  // that is the accept edge itself, so live inputs are used instead of the
  // captured copy
  always_comb begin
    enter_resp  = (next_state == DMEM_RESP) && !ms_riscv32_mp_rst_in;
    op_idx      = ms_riscv32_mp_dmaddr_in[31:2];
    op_data     = ms_riscv32_mp_dmdata_in;
    op_mask     = ms_riscv32_mp_dmwr_mask_in;
    op_write    = live_write;
    if (state == DMEM_WAIT) begin
      op_idx   = cap_idx;
      op_data  = cap_data;
      op_mask  = cap_mask;
      op_write = cap_write;
    end
    op_in_range = ({2'b00, op_idx} < 32'(DEPTH_WORDS));
    ram_we      = (enter_resp && op_write && op_in_range) ? op_mask : 4'b0000;
    ram_re      = enter_resp && !op_write && op_in_range;
  end

  msrv32_dmem_bytelane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (IDX_W)
  ) u_ram (
    .clk  (ms_riscv32_mp_clk_in),
    .addr (op_idx[IDX_W-1:0]),
    .we   (ram_we),
    .re   (ram_re),
    .wdata(op_data),
    .rdata(ram_rdata)
  );

  // State, wait counter, transfer capture and response flags
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state    <= DMEM_IDLE;
      wait_cnt <= 4'd0;
      resp_err <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      state <= next_state;
      if (accept) begin
        wait_cnt  <= WAIT_LOAD;
        cap_idx   <= ms_riscv32_mp_dmaddr_in[31:2];
        cap_data  <= ms_riscv32_mp_dmdata_in;
        cap_mask  <= ms_riscv32_mp_dmwr_mask_in;
        cap_write <= live_write;
      end else if ((state == DMEM_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      resp_err <= enter_resp && !op_in_range;
      if (enter_resp && !op_write) begin
        rd_zero <= !op_in_range;
      end
    end
  end

  assign ahb_hresp_out            = resp_err;
  assign ms_riscv32_mp_dmdata_out = rd_zero ? 32'd0 : ram_rdata;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Directed bench for msrv32_dmem_responder: one instance with no wait states
// and one with three, driven from a single linear sequence.
module tb_msrv32_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3;
  logic [31:0] addr0, data0, addr3, data3;
  logic [3:0]  mask0, mask3;
  logic        req0, req3;
  logic [1:0]  htrans0, htrans3;
  logic [31:0] dout0, dout3;
  logic        ready0, ready3, hresp0, hresp3;

  int checks   = 0;
  int failures = 0;

  msrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .ms_riscv32_mp_clk_in      (clk),
    .ms_riscv32_mp_rst_in      (rst0),
    .ms_riscv32_mp_dmaddr_in   (addr0),
    .ms_riscv32_mp_dmdata_in   (data0),
    .ms_riscv32_mp_dmwr_mask_in(mask0),
    .ms_riscv32_mp_req_in      (req0),
    .ahb_htrans_in             (htrans0),
    .ms_riscv32_mp_dmdata_out  (dout0),
    .ahb_ready_out             (ready0),
    .ahb_hresp_out             (hresp0)
  );

  msrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .ms_riscv32_mp_clk_in      (clk),
    .ms_riscv32_mp_rst_in      (rst3),
    .ms_riscv32_mp_dmaddr_in   (addr3),
    .ms_riscv32_mp_dmdata_in   (data3),
    .ms_riscv32_mp_dmwr_mask_in(mask3),
    .ms_riscv32_mp_req_in      (req3),
    .ahb_htrans_in             (htrans3),
    .ms_riscv32_mp_dmdata_out  (dout3),
    .ahb_ready_out             (ready3),
    .ahb_hresp_out             (hresp3)
  );

  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m, input logic r, input logic [1:0] h);
    if (sel == 0) begin
      addr0 = a; data0 = d; mask0 = m; req0 = r; htrans0 = h;
    end else begin
      addr3 = a; data3 = d; mask3 = m; req3 = r; htrans3 = h;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    rst0 = 1'b1;
    rst3 = 1'b1;
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    applyStimulus(3, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    tick();
    tick();
    rst0 = 1'b0;
    rst3 = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_ready0", {31'd0, ready0}, 32'd1);
    checkOutput("rst_hresp0", {31'd0, hresp0}, 32'd0);
    checkOutput("rst_dout0",  dout0, 32'd0);
    checkOutput("rst_ready3", {31'd0, ready3}, 32'd1);
    checkOutput("rst_hresp3", {31'd0, hresp3}, 32'd0);
    checkOutput("rst_dout3",  dout3, 32'd0);

    $display("[TB] word write then back-to-back read, no wait states");
    applyStimulus(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, 2'b10);
    tick();
    checkOutput("wr_resp_ready", {31'd0, ready0}, 32'd1);
    checkOutput("wr_resp_dout",  dout0, 32'd0);
    applyStimulus(0, 32'h0000_0010, 32'h0, 4'b0000, 1'b0, 2'b10);
    tick();
    checkOutput("rd_resp_dout",  dout0, 32'hDEAD_BEEF);
    checkOutput("rd_resp_hresp", {31'd0, hresp0}, 32'd0);
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    tick();
    checkOutput("rd_hold_dout", dout0, 32'hDEAD_BEEF);

    $display("[TB] byte and halfword lanes");
    applyStimulus(0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 1'b1, 2'b10);
    tick();
    applyStimulus(0, 32'h0000_0020, 32'h00AB_0000, 4'b0100, 1'b1, 2'b11);
    tick();
    applyStimulus(0, 32'h0000_0020, 32'h0000_1234, 4'b0011, 1'b1, 2'b10);
    tick();
    applyStimulus(0, 32'h0000_0022, 32'h0, 4'b0000, 1'b0, 2'b10);
    tick();
    checkOutput("lane_merge", dout0, 32'h00AB_1234);

    $display("[TB] out-of-range transfers");
    applyStimulus(0, 32'h0000_0000, 32'h55AA_55AA, 4'b1111, 1'b1, 2'b10);
    tick();
    applyStimulus(0, 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 2'b10);
    tick();
    checkOutput("err_rd_hresp", {31'd0, hresp0}, 32'd1);
    checkOutput("err_rd_dout",  dout0, 32'd0);
    checkOutput("err_rd_ready", {31'd0, ready0}, 32'd1);
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    tick();
    checkOutput("err_clear_hresp", {31'd0, hresp0}, 32'd0);
    applyStimulus(0, 32'h0000_1000, 32'hCAFE_F00D, 4'b1111, 1'b1, 2'b10);
    tick();
    checkOutput("err_wr_hresp", {31'd0, hresp0}, 32'd1);
    applyStimulus(0, 32'h8000_0000, 32'h1357_9BDF, 4'b1111, 1'b1, 2'b10);
    tick();
    checkOutput("err_hi_hresp", {31'd0, hresp0}, 32'd1);
    checkOutput("err_wr_dout",  dout0, 32'd0);
    applyStimulus(0, 32'h0000_0000, 32'h0, 4'b0000, 1'b0, 2'b10);
    tick();
    checkOutput("err_no_alias", dout0, 32'h55AA_55AA);
    checkOutput("ok_hresp",     {31'd0, hresp0}, 32'd0);
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);

    $display("[TB] wait states");
    applyStimulus(3, 32'h0000_0040, 32'h0BAD_F00D, 4'b1111, 1'b1, 2'b10);
    tick();
    checkOutput("ws_wr_t1", {31'd0, ready3}, 32'd0);
    tick();
    tick();
    checkOutput("ws_wr_t3", {31'd0, ready3}, 32'd0);
    applyStimulus(3, 32'h0000_0040, 32'h0, 4'b0000, 1'b0, 2'b10);
    tick();
    checkOutput("ws_wr_t4", {31'd0, ready3}, 32'd1);
    tick();
    checkOutput("ws_rd_t1", {31'd0, ready3}, 32'd0);
    applyStimulus(3, 32'h0000_0040, 32'hFFFF_FFFF, 4'b1111, 1'b1, 2'b11);
    tick();
    checkOutput("ws_rd_t2", {31'd0, ready3}, 32'd0);
    tick();
    checkOutput("ws_rd_t3", {31'd0, ready3}, 32'd0);
    checkOutput("ws_rd_t3_dout", dout3, 32'd0);
    applyStimulus(3, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    tick();
    checkOutput("ws_rd_t4", {31'd0, ready3}, 32'd1);
    checkOutput("ws_rd_dout", dout3, 32'h0BAD_F00D);
    applyStimulus(3, 32'h0000_0040, 32'h0, 4'b0000, 1'b0, 2'b01);
    tick();
    checkOutput("busy_no_xfer", {31'd0, ready3}, 32'd1);
    applyStimulus(3, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);

    $display("[TB] reset during wait states");
    applyStimulus(3, 32'h0000_0030, 32'h2222_2222, 4'b1111, 1'b1, 2'b10);
    tick();
    applyStimulus(3, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    tick();
    tick();
    tick();
    tick();
    applyStimulus(3, 32'h0000_0030, 32'h1111_1111, 4'b1111, 1'b1, 2'b10);
    tick();
    applyStimulus(3, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    tick();
    checkOutput("mid_wait_ready", {31'd0, ready3}, 32'd0);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    checkOutput("post_rst_ready", {31'd0, ready3}, 32'd1);
    checkOutput("post_rst_hresp", {31'd0, hresp3}, 32'd0);
    checkOutput("post_rst_dout",  dout3, 32'd0);
    tick();
    tick();
    applyStimulus(3, 32'h0000_0030, 32'h0, 4'b0000, 1'b0, 2'b10);
    tick();
    applyStimulus(3, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
    tick();
    tick();
    tick();
    checkOutput("abandoned_wr", dout3, 32'h2222_2222);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
